// File: rtl/seq_shift_add_multiplier_pkg.sv
// rtl/seq_shift_add_multiplier_pkg.sv - shared types and helpers for the shift-add multiplier
package seq_shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_sign_fix.sv
// rtl/seq_shift_add_multiplier_sign_fix.sv - conditional two's-complement negate
module seq_shift_add_multiplier_sign_fix #(
    parameter int W = 4
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative radix-2 shift-add multiplier with handshakes
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    mult_state_t       state;
    mult_state_t       state_nxt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     ma;
    logic [WIDTH-1:0]  mb;
    logic [CW-1:0]     cnt;
    logic              neg;

    logic              signed_op;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [PW-1:0]     sum;
    logic [PW-1:0]     result;

    assign signed_op = in_signed & (SIGNED_EN != 0);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(1));
    assign sum       = acc + (mb[0] ? ma : '0);

    // The most-negative operand maps onto itself, which read unsigned is its magnitude.
    seq_shift_add_multiplier_sign_fix #(.W(WIDTH)) u_fix_a (
        .din  (in_a),
        .neg  (signed_op & in_a[WIDTH-1]),
        .dout (a_mag)
    );

    seq_shift_add_multiplier_sign_fix #(.W(WIDTH)) u_fix_b (
        .din  (in_b),
        .neg  (signed_op & in_b[WIDTH-1]),
        .dout (b_mag)
    );

    seq_shift_add_multiplier_sign_fix #(.W(PW)) u_fix_p (
        .din  (sum),
        .neg  (neg),
        .dout (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_BUSY;
            ST_BUSY: if (last)     state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            ma    <= '0;
            mb    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            out_p <= '0;
        end else if (accept) begin
            acc <= '0;
            ma  <= {{WIDTH{1'b0}}, a_mag};
            mb  <= b_mag;
            cnt <= CW'(WIDTH);
            neg <= signed_op & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        end else if (state == ST_BUSY) begin
            acc <= sum;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt - CW'(1);
            // Final partial product is folded in here rather than one cycle later.
            if (last) begin
                out_p <= result;
            end
        end
    end

endmodule
